// File: rtl/aurora_cmd_wbmaster.sv
// Bridges an addr/data command stream pair onto a single-outstanding Wishbone
// master, returning read data (or all-ones on error/timeout) on a response stream.
module aurora_cmd_wbmaster #(
    parameter int ADDR_BITS = 22,
    parameter int TIMEOUT   = 255
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [31:0]          s_cmd_addr_tdata,
    input  logic                 s_cmd_addr_tvalid,
    output logic                 s_cmd_addr_tready,
    input  logic [31:0]          s_cmd_data_tdata,
    input  logic                 s_cmd_data_tvalid,
    output logic                 s_cmd_data_tready,
    output logic [31:0]          m_resp_tdata,
    output logic                 m_resp_tvalid,
    input  logic                 m_resp_tready,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [ADDR_BITS-1:0] wb_adr_o,
    output logic [31:0]          wb_dat_o,
    output logic [3:0]           wb_sel_o,
    input  logic [31:0]          wb_dat_i,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    output logic [7:0]           err_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    logic [1:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] adr_q, adr_d;
    logic                 we_q, we_d;
    logic [31:0]          dat_q, dat_d;
    logic [31:0]          resp_data_q, resp_data_d;
    logic                 resp_vld_q, resp_vld_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic [7:0]           tmo_q, tmo_d;
    logic                 start_wr, start_rd, tmo_hit, bus_end, bus_fail;

    // Address bits above ADDR_BITS (below the read flag) carry no meaning.
    logic unused_addr_bits;
    assign unused_addr_bits = ^s_cmd_addr_tdata[30:ADDR_BITS];

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        we_d        = we_q;
        dat_d       = dat_q;
        resp_data_d = resp_data_q;
        resp_vld_d  = resp_vld_q;
        err_cnt_d   = err_cnt_q;
        tmo_d       = tmo_q;

        start_wr = s_cmd_addr_tvalid && !s_cmd_addr_tdata[31] && s_cmd_data_tvalid;
        // A read may only launch once the response slot is free, so it can never block.
        start_rd = s_cmd_addr_tvalid && s_cmd_addr_tdata[31] && !resp_vld_q;
        tmo_hit  = (tmo_q == TMO_LIMIT);
        bus_end  = wb_ack_i || wb_err_i || tmo_hit;
        bus_fail = wb_err_i || (!wb_ack_i && tmo_hit);

        if (resp_vld_q && m_resp_tready) begin
            resp_vld_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_wr || start_rd) begin
                    state_d = ST_BUS;
                    adr_d   = s_cmd_addr_tdata[ADDR_BITS-1:0];
                    we_d    = !s_cmd_addr_tdata[31];
                    tmo_d   = 8'd0;
                    if (start_wr) begin
                        dat_d = s_cmd_data_tdata;
                    end
                end
            end
            ST_BUS: begin
                tmo_d = tmo_q + 8'd1;
                if (bus_end) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        resp_data_d = bus_fail ? 32'hFFFF_FFFF : wb_dat_i;
                    end
                    if (bus_fail && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!we_q) begin
                    resp_vld_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            we_q        <= 1'b0;
            dat_q       <= '0;
            resp_data_q <= '0;
            resp_vld_q  <= 1'b0;
            err_cnt_q   <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            we_q        <= we_d;
            dat_q       <= dat_d;
            resp_data_q <= resp_data_d;
            resp_vld_q  <= resp_vld_d;
            err_cnt_q   <= err_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign wb_cyc_o          = (state_q == ST_BUS);
    assign wb_stb_o          = (state_q == ST_BUS);
    assign wb_we_o           = we_q;
    assign wb_adr_o          = adr_q;
    assign wb_dat_o          = dat_q;
    assign wb_sel_o          = 4'hF;
    assign s_cmd_addr_tready = (state_q == ST_DONE);
    assign s_cmd_data_tready = (state_q == ST_DONE) && we_q;
    assign m_resp_tdata      = resp_data_q;
    assign m_resp_tvalid     = resp_vld_q;
    assign err_count         = err_cnt_q;

endmodule

// File: tb/tb_aurora_cmd_wbmaster.sv
// Bench for aurora_cmd_wbmaster: vector table, directed corner sequences and a
// randomized command stream checked against a queue-based transaction model.
module tb_aurora_cmd_wbmaster;

    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic [31:0] s_cmd_addr_tdata = '0;
    logic        s_cmd_addr_tvalid = 1'b0;
    logic        s_cmd_addr_tready;
    logic [31:0] s_cmd_data_tdata = '0;
    logic        s_cmd_data_tvalid = 1'b0;
    logic        s_cmd_data_tready;
    logic [31:0] m_resp_tdata;
    logic        m_resp_tvalid;
    logic        m_resp_tready = 1'b0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [21:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic [7:0]  err_count;

    aurora_cmd_wbmaster #(.ADDR_BITS(22), .TIMEOUT(255)) dut (
        .aclk(aclk), .areset(areset),
        .s_cmd_addr_tdata(s_cmd_addr_tdata), .s_cmd_addr_tvalid(s_cmd_addr_tvalid),
        .s_cmd_addr_tready(s_cmd_addr_tready),
        .s_cmd_data_tdata(s_cmd_data_tdata), .s_cmd_data_tvalid(s_cmd_data_tvalid),
        .s_cmd_data_tready(s_cmd_data_tready),
        .m_resp_tdata(m_resp_tdata), .m_resp_tvalid(m_resp_tvalid), .m_resp_tready(m_resp_tready),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .err_count(err_count)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // mode: 0 = ack, 1 = err, 2 = ack and err together
    task automatic do_txn(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                          input int dly, input int mode, input logic [31:0] rdat,
                          input logic [31:0] exp_resp, input logic [31:0] exp_adr,
                          input bit do_chk, input bit accept);
        s_cmd_addr_tdata  = addr;
        s_cmd_addr_tvalid = 1'b1;
        s_cmd_data_tdata  = wd;
        s_cmd_data_tvalid = !rd;
        if (do_chk) chk("pre_bus_cyc", 32'(wb_cyc_o), 32'd0);
        tick();
        if (do_chk) begin
            chk("bus_cyc", 32'(wb_cyc_o), 32'd1);
            chk("bus_stb", 32'(wb_stb_o), 32'd1);
            chk("bus_we", 32'(wb_we_o), 32'(!rd));
            chk("bus_adr", 32'(wb_adr_o), exp_adr);
            chk("bus_sel", 32'(wb_sel_o), 32'hF);
            chk("bus_addr_rdy", 32'(s_cmd_addr_tready), 32'd0);
            if (!rd) chk("bus_wdat", wb_dat_o, wd);
        end
        for (int i = 0; i < dly; i++) begin
            tick();
            if (do_chk) chk("bus_wait_cyc", 32'(wb_cyc_o), 32'd1);
        end
        wb_dat_i = rdat;
        wb_ack_i = (mode != 1);
        wb_err_i = (mode != 0);
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        if (do_chk) begin
            chk("done_cyc", 32'(wb_cyc_o), 32'd0);
            chk("done_addr_rdy", 32'(s_cmd_addr_tready), 32'd1);
            chk("done_data_rdy", 32'(s_cmd_data_tready), 32'(!rd));
            chk("done_resp_vld", 32'(m_resp_tvalid), 32'd0);
        end
        tick();
        s_cmd_addr_tvalid = 1'b0;
        s_cmd_data_tvalid = 1'b0;
        if (do_chk) begin
            chk("post_addr_rdy", 32'(s_cmd_addr_tready), 32'd0);
            chk("post_data_rdy", 32'(s_cmd_data_tready), 32'd0);
            chk("post_resp_vld", 32'(m_resp_tvalid), 32'(rd));
            if (rd) chk("post_resp_data", m_resp_tdata, exp_resp);
        end
        if (rd && accept) begin
            m_resp_tready = 1'b1;
            tick();
            m_resp_tready = 1'b0;
            if (do_chk) chk("resp_clear", 32'(m_resp_tvalid), 32'd0);
        end
    endtask

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wd;
        int          dly;
        int          mode;
        logic [31:0] rdat;
        logic [31:0] exp_resp;
        logic [31:0] exp_adr;
        logic [7:0]  exp_ec;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } cmd_t;

    vec_t        vecs[6];
    cmd_t        up_q[$];
    cmd_t        exp_q[$];
    logic [31:0] dq[$];
    logic [31:0] rq[$];
    cmd_t        h, last_term, c;
    int          exp_ec, n, r, cyc_cnt;
    bit          ashow, dshow, tack, terr;

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0010, 32'hA5A5_A5A5, 0, 0, 32'h0,         32'h0,         32'h10,     8'd0};
        vecs[1] = '{1'b1, 32'h8000_0024, 32'h0,         0, 0, 32'h1234_5678, 32'h1234_5678, 32'h24,     8'd0};
        vecs[2] = '{1'b1, 32'h8000_0100, 32'h0,         3, 1, 32'h0BAD_0BAD, 32'hFFFF_FFFF, 32'h100,    8'd1};
        vecs[3] = '{1'b0, 32'h0000_0200, 32'h0BAD_F00D, 2, 1, 32'h0,         32'h0,         32'h200,    8'd2};
        vecs[4] = '{1'b1, 32'h8000_0040, 32'h0,         1, 2, 32'h55AA_55AA, 32'hFFFF_FFFF, 32'h40,     8'd3};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'h0,         0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h3F_FFFF, 8'd3};

        areset = 1'b1;
        tick();
        tick();
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_adr", 32'(wb_adr_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_resp_vld", 32'(m_resp_tvalid), 32'd0);
        chk("rst_resp_data", m_resp_tdata, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_addr_rdy", 32'(s_cmd_addr_tready), 32'd0);
        chk("rst_data_rdy", 32'(s_cmd_data_tready), 32'd0);
        areset = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            do_txn(vecs[v].rd, vecs[v].addr, vecs[v].wd, vecs[v].dly, vecs[v].mode,
                   vecs[v].rdat, vecs[v].exp_resp, vecs[v].exp_adr, 1'b1, 1'b1);
            chk("vec_err_count", 32'(err_count), 32'(vecs[v].exp_ec));
        end

        // Write address waits ten cycles for its data.
        s_cmd_addr_tdata  = 32'h0000_0050;
        s_cmd_addr_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("nodata_cyc", 32'(wb_cyc_o), 32'd0);
            chk("nodata_addr_rdy", 32'(s_cmd_addr_tready), 32'd0);
        end
        do_txn(1'b0, 32'h0000_0050, 32'h1357_2468, 0, 0, 32'h0, 32'h0, 32'h50, 1'b1, 1'b1);

        // Second read stalls while the first response is unaccepted.
        do_txn(1'b1, 32'h8000_0060, 32'h0, 0, 0, 32'h1111_1111, 32'h1111_1111, 32'h60, 1'b1, 1'b0);
        s_cmd_addr_tdata  = 32'h8000_0064;
        s_cmd_addr_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_cyc", 32'(wb_cyc_o), 32'd0);
            chk("bp_resp_vld", 32'(m_resp_tvalid), 32'd1);
            chk("bp_resp_data", m_resp_tdata, 32'h1111_1111);
        end
        m_resp_tready = 1'b1;
        tick();
        m_resp_tready = 1'b0;
        chk("bp_resp_clear", 32'(m_resp_tvalid), 32'd0);
        do_txn(1'b1, 32'h8000_0064, 32'h0, 0, 0, 32'h2222_2222, 32'h2222_2222, 32'h64, 1'b1, 1'b1);

        // Reset while the bus cycle is open.
        s_cmd_addr_tdata  = 32'h8000_0008;
        s_cmd_addr_tvalid = 1'b1;
        tick();
        chk("rbus_cyc", 32'(wb_cyc_o), 32'd1);
        areset = 1'b1;
        tick();
        s_cmd_addr_tvalid = 1'b0;
        chk("rbus_cyc_drop", 32'(wb_cyc_o), 32'd0);
        chk("rbus_stb_drop", 32'(wb_stb_o), 32'd0);
        chk("rbus_addr_rdy", 32'(s_cmd_addr_tready), 32'd0);
        chk("rbus_err_count", 32'(err_count), 32'd0);
        areset = 1'b0;
        tick();
        chk("rbus_no_rdy", 32'(s_cmd_addr_tready), 32'd0);

        // Unanswered read times out after 256 bus cycles.
        s_cmd_addr_tdata  = 32'h8000_0300;
        s_cmd_addr_tvalid = 1'b1;
        tick();
        n = 0;
        while (wb_cyc_o && n < 400) begin
            n++;
            tick();
        end
        chk("tmo_cycles", 32'(n), 32'd256);
        chk("tmo_addr_rdy", 32'(s_cmd_addr_tready), 32'd1);
        tick();
        s_cmd_addr_tvalid = 1'b0;
        chk("tmo_resp_vld", 32'(m_resp_tvalid), 32'd1);
        chk("tmo_resp_data", m_resp_tdata, 32'hFFFF_FFFF);
        chk("tmo_err_count", 32'(err_count), 32'd1);
        m_resp_tready = 1'b1;
        tick();
        m_resp_tready = 1'b0;
        exp_ec = 1;

        // Randomized command stream against the transaction model.
        for (int i = 0; i < 40; i++) begin
            c.a = $urandom;
            c.d = $urandom;
            up_q.push_back(c);
            exp_q.push_back(c);
            if (!c.a[31]) dq.push_back(c.d);
        end
        ashow = 1'b0;
        dshow = 1'b0;
        cyc_cnt = 0;
        while ((exp_q.size() != 0 || rq.size() != 0 || up_q.size() != 0) && cyc_cnt < 4000) begin
            tack = 1'b0;
            terr = 1'b0;
            if (wb_cyc_o) begin
                r = $urandom_range(0, 7);
                tack = (r <= 3) || (r == 5);
                terr = (r == 4) || (r == 5);
            end
            wb_ack_i = tack;
            wb_err_i = terr;
            wb_dat_i = $urandom;
            if (wb_cyc_o && (tack || terr)) begin
                if (exp_q.size() == 0) chk("rand_extra_bus", 32'd1, 32'd0);
                else begin
                    h = exp_q.pop_front();
                    last_term = h;
                    chk("rand_we", 32'(wb_we_o), 32'(!h.a[31]));
                    chk("rand_adr", 32'(wb_adr_o), 32'(h.a[21:0]));
                    if (!h.a[31]) chk("rand_wdat", wb_dat_o, h.d);
                    else rq.push_back(terr ? 32'hFFFF_FFFF : wb_dat_i);
                    if (terr && exp_ec < 255) exp_ec++;
                end
            end
            if (up_q.size() != 0 && (ashow || $urandom_range(0, 3) != 0)) begin
                ashow = 1'b1;
                s_cmd_addr_tvalid = 1'b1;
                s_cmd_addr_tdata  = up_q[0].a;
            end else s_cmd_addr_tvalid = 1'b0;
            if (dq.size() != 0 && (dshow || $urandom_range(0, 2) != 0)) begin
                dshow = 1'b1;
                s_cmd_data_tvalid = 1'b1;
                s_cmd_data_tdata  = dq[0];
            end else s_cmd_data_tvalid = 1'b0;
            m_resp_tready = 1'($urandom_range(0, 1));
            if (s_cmd_addr_tvalid && s_cmd_addr_tready) begin
                h = up_q.pop_front();
                ashow = 1'b0;
                chk("rand_addr_order", h.a, last_term.a);
            end
            if (s_cmd_data_tvalid && s_cmd_data_tready) begin
                void'(dq.pop_front());
                dshow = 1'b0;
            end
            if (m_resp_tvalid && m_resp_tready) begin
                if (rq.size() == 0) chk("rand_extra_resp", 32'd1, 32'd0);
                else chk("rand_resp", m_resp_tdata, rq.pop_front());
            end
            tick();
            cyc_cnt++;
        end
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        s_cmd_addr_tvalid = 1'b0;
        s_cmd_data_tvalid = 1'b0;
        m_resp_tready = 1'b0;
        chk("rand_drain", 32'(exp_q.size() + up_q.size() + rq.size() + dq.size()), 32'd0);
        chk("rand_err_count", 32'(err_count), 32'(exp_ec));

        // Error counter saturation.
        areset = 1'b1;
        tick();
        areset = 1'b0;
        tick();
        for (int i = 0; i < 255; i++)
            do_txn(1'b0, 32'h0000_0004, 32'h0, 0, 1, 32'h0, 32'h0, 32'h4, 1'b0, 1'b1);
        chk("sat_err_count_255", 32'(err_count), 32'hFF);
        do_txn(1'b0, 32'h0000_0004, 32'h0, 0, 1, 32'h0, 32'h0, 32'h4, 1'b0, 1'b1);
        chk("sat_err_count_hold", 32'(err_count), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aurora_cmd_wbmaster.md
AURORA_CMD_WBMASTER -- requirements
Module: aurora_cmd_wbmaster

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_BITS, 22, width of wb_adr_o.
- TIMEOUT, 255, maximum BUS-state cycles without ack/err before forced termination, valid range 1..255.
REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- aclk, in, 1, sole clock.
- areset, in, 1, synchronous reset, active-high.
- s_cmd_addr_tdata, in, 32, command word: bit31=1 read, bit31=0 write, bits[ADDR_BITS-1:0] address.
- s_cmd_addr_tvalid, in, 1, command word valid.
- s_cmd_addr_tready, out, 1, command word consumed.
- s_cmd_data_tdata, in, 32, write data.
- s_cmd_data_tvalid, in, 1, write data valid.
- s_cmd_data_tready, out, 1, write data consumed.
- m_resp_tdata, out, 32, read response data.
- m_resp_tvalid, out, 1, response valid.
- m_resp_tready, in, 1, response accepted.
- wb_cyc_o, out, 1, Wishbone cycle.
- wb_stb_o, out, 1, Wishbone strobe.
- wb_we_o, out, 1, Wishbone write enable.
- wb_adr_o, out, ADDR_BITS, Wishbone address.
- wb_dat_o, out, 32, Wishbone write data.
- wb_sel_o, out, 4, Wishbone byte selects.
- wb_dat_i, in, 32, Wishbone read data.
- wb_ack_i, in, 1, Wishbone acknowledge.
- wb_err_i, in, 1, Wishbone error.
- err_count, out, 8, saturating count of errored or timed-out transactions.

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, BUS and DONE.
REQ-004 IDLE -> BUS SHALL occur when either condition holds:
- s_cmd_addr_tvalid && !tdata[31] && s_cmd_data_tvalid (write).
- s_cmd_addr_tvalid && tdata[31] && !m_resp_tvalid (read; a read SHALL never start while the response register is occupied, for deadlock avoidance).
REQ-005 On the IDLE->BUS transition the block SHALL register:
- wb_adr_o from addr tdata[ADDR_BITS-1:0].
- wb_we_o as !tdata[31].
- wb_dat_o from s_cmd_data_tdata on writes; unchanged on reads.
REQ-006 wb_cyc_o and wb_stb_o SHALL both be 1 exactly while in BUS; wb_sel_o SHALL be constant 4'hF.
REQ-007 BUS SHALL terminate and move to DONE on the first cycle in which any of these holds: wb_ack_i, wb_err_i, or the timeout counter equals TIMEOUT.
REQ-008 The timeout counter SHALL clear on BUS entry and increment each BUS cycle.
REQ-009 If ack and err are both asserted in the same cycle, err SHALL take priority.
REQ-010 On a read termination the response register SHALL capture:
- wb_dat_i on ack.
- 32'hFFFFFFFF on err or timeout.
REQ-011 On a write termination the response register SHALL be left unchanged; writes SHALL produce no response.
REQ-012 On err or timeout, err_count SHALL increment by 1 and saturate at 8'hFF.
REQ-013 In DONE, the block SHALL for exactly one cycle:
- assert s_cmd_addr_tready.
- assert s_cmd_data_tready if the transaction was a write.
- if the transaction was a read, assert m_resp_tvalid starting the next cycle.
REQ-014 DONE -> IDLE SHALL occur unconditionally after one cycle.
REQ-015 s_cmd_addr_tready and s_cmd_data_tready SHALL be 0 in every state other than DONE.
REQ-016 m_resp_tvalid SHALL remain high, with m_resp_tdata stable, until m_resp_tready is seen; it SHALL then clear on the following edge.
REQ-017 A read whose response register is still occupied SHALL stall in IDLE; writes presented meanwhile SHALL still wait behind it, preserving in-order processing of the addr stream.
REQ-018 A write address without data SHALL wait in IDLE with no bus activity.
REQ-019 Data without a write address SHALL be neither consumed nor discarded.
REQ-020 Minimum latency for write or read with ack in the first BUS cycle:
- addr/data valid at cycle N.
- cyc/stb at N+1.
- tready at N+2.
- m_resp_tvalid (read) at N+3.
- next command accepted in IDLE at N+3.

Reset
REQ-021 While areset=1 at a clock edge, the block SHALL set:
- state = IDLE.
- wb_cyc_o = wb_stb_o = wb_we_o = 0.
- wb_adr_o = 0, wb_dat_o = 0.
- m_resp_tvalid = 0, m_resp_tdata = 0.
- err_count = 0.
- both treadys = 0.
- timeout counter = 0.
REQ-022 Reset asserted during BUS SHALL drop cyc/stb on the next edge and SHALL NOT consume the pending command words; the upstream is reset alongside.

Verification
REQ-023 Write: addr 0x00000010, data 0xA5A5A5A5, ack one cycle after stb -> one bus cycle with we=1, adr=0x10, dat_o=0xA5A5A5A5; both treadys pulse once; no response.
REQ-024 Read: addr 0x80000024, wb_dat_i 0x12345678 on ack -> we=0, adr=0x24; addr tready pulses once; m_resp 0x12345678 held until tready.
REQ-025 Back-pressure: two reads with m_resp_tready=0 -> second read issues no cyc until the first response is accepted; responses arrive in order.
REQ-026 Timeout: read to an address never acked, TIMEOUT=255 -> cyc held 256 cycles, response 0xFFFFFFFF, err_count=1.
REQ-027 Write addr present with data delayed 10 cycles -> no cyc until data valid, then normal write.
REQ-028 Reset mid-BUS -> cyc/stb low next cycle, err_count=0, no tready pulse.
